// File: rtl/lsu_pkg.sv
// Shared state encodings, funct3 codes and size decode for the load/store alignment unit.
package lsu_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_D  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    localparam logic [2:0] LD_WU = 3'b110;

    localparam logic [2:0] ST_B = 3'b000;
    localparam logic [2:0] ST_H = 3'b001;
    localparam logic [2:0] ST_W = 3'b010;
    localparam logic [2:0] ST_D = 3'b011;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

    function automatic logic [7:0] byte_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Doubleword codes are only legal on a 64-bit datapath.
    function automatic logic is_reserved(input logic we, input logic [2:0] funct3,
                                         input logic xlen64);
        logic store_ok;
        store_ok = (funct3 == ST_B) || (funct3 == ST_H) || (funct3 == ST_W) || (funct3 == ST_D);
        return (funct3 == 3'b111) || (we && !store_ok) || (!xlen64 && funct3[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a right-aligned load word according to the load funct3.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    localparam int NB = XLEN / 8;

    logic [3:0] nbytes;
    logic       sign;

    always_comb begin
        nbytes = size_bytes(funct3);
        case (funct3)
            LD_B:    sign = word[7];
            LD_H:    sign = word[15];
            LD_W:    sign = word[31];
            LD_D:    sign = word[XLEN-1];
            default: sign = 1'b0;
        endcase
        result = word;
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(nbytes)) result[8*i +: 8] = {8{sign}};
        end
    end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: lane shifting, write strobes, load extension and
// optional two-beat splitting of accesses that straddle a bus word.
module lsu_align_unit
    import lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_fault,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic [2:0]          fsm_state
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    // Handshake: mem_valid is held with stable addr/wdata/wstrb until mem_valid && mem_ready;
    // exactly one mem_rvalid follows each accepted beat and is only taken in WAITn.

    logic [2:0]      state;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_base;
    logic [OW-1:0]   r_off;
    logic [XLEN-1:0] r_wdata;
    logic            r_split;
    logic            r_fault;
    logic [XLEN-1:0] buf0;
    logic [XLEN-1:0] buf1;

    logic [OW-1:0]   req_off;
    logic [3:0]      req_size;
    logic            req_misaligned;
    logic            req_split;
    logic            req_fault;

    always_comb begin
        req_off        = req_addr[OW-1:0];
        req_size       = size_bytes(req_funct3);
        req_misaligned = (4'(req_off) & (req_size - 4'd1)) != 4'd0;
        req_split      = (4'(req_off) + req_size) > 4'(NB);
        req_fault      = is_reserved(req_we, req_funct3, XLEN == 64)
                         || (req_misaligned && !ALLOW_MISALIGNED);
    end

    // Two-word views: the low half is beat 0, the high half spills into beat 1.
    logic [2*NB-1:0]   strb_wide;
    logic [2*XLEN-1:0] wdata_wide;
    logic [XLEN-1:0]   load_word;
    logic [XLEN-1:0]   load_ext;

    always_comb begin
        strb_wide  = (2*NB)'(byte_mask(r_funct3)) << r_off;
        wdata_wide = (2*XLEN)'(r_wdata) << {r_off, 3'b000};
        load_word  = XLEN'({buf1, buf0} >> {r_off, 3'b000});
    end

    lsu_load_extend #(.XLEN(XLEN)) u_extend (
        .word   (load_word),
        .funct3 (r_funct3),
        .result (load_ext)
    );

    logic in_req;
    logic beat1;

    always_comb begin
        in_req     = (state == S_REQ0) || (state == S_REQ1);
        beat1      = (state == S_REQ1);
        req_ready  = (state == S_IDLE);
        mem_valid  = in_req;
        mem_we     = in_req && r_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        if (in_req) begin
            mem_addr = beat1 ? r_base + XLEN'(NB) : r_base;
            if (r_we) begin
                mem_wstrb = beat1 ? strb_wide[2*NB-1:NB] : strb_wide[NB-1:0];
                mem_wdata = beat1 ? wdata_wide[2*XLEN-1:XLEN] : wdata_wide[XLEN-1:0];
            end
        end
        resp_valid = (state == S_RESP);
        resp_fault = resp_valid && r_fault;
        resp_rdata = (resp_valid && !r_we && !r_fault) ? load_ext : '0;
        fsm_state  = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_base   <= '0;
            r_off    <= '0;
            r_wdata  <= '0;
            r_split  <= 1'b0;
            r_fault  <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_base   <= {req_addr[XLEN-1:OW], {OW{1'b0}}};
                        r_off    <= req_off;
                        r_wdata  <= req_wdata;
                        r_split  <= req_split;
                        r_fault  <= req_fault;
                        buf0     <= '0;
                        buf1     <= '0;
                        state    <= req_fault ? S_RESP : S_REQ0;
                    end
                end
                S_REQ0:  if (mem_ready) state <= S_WAIT0;
                S_WAIT0: begin
                    if (mem_rvalid) begin
                        buf0  <= mem_rdata;
                        state <= r_split ? S_REQ1 : S_RESP;
                    end
                end
                S_REQ1:  if (mem_ready) state <= S_WAIT1;
                S_WAIT1: begin
                    if (mem_rvalid) begin
                        buf1  <= mem_rdata;
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Bench for lsu_align_unit: three configurations, a byte-level memory model and a reference load/store model.
module tb_lsu_align_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata, bus_rdata;
    logic [2:0]  rv, mr, mrv;

    logic        a_req_ready, a_resp_valid, a_resp_fault, a_mem_valid, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;
    logic [2:0]  a_state;
    logic        b_req_ready, b_resp_valid, b_resp_fault, b_mem_valid, b_mem_we;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;
    logic [2:0]  b_state;
    logic        c_req_ready, c_resp_valid, c_resp_fault, c_mem_valid, c_mem_we;
    logic [63:0] c_resp_rdata, c_mem_addr, c_mem_wdata;
    logic [7:0]  c_mem_wstrb;
    logic [2:0]  c_state;

    lsu_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(a_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault),
        .mem_valid(a_mem_valid), .mem_ready(mr[0]), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rvalid(mrv[0]),
        .mem_rdata(bus_rdata[31:0]), .fsm_state(a_state));

    lsu_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_b (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(b_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_fault(b_resp_fault),
        .mem_valid(b_mem_valid), .mem_ready(mr[1]), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rvalid(mrv[1]),
        .mem_rdata(bus_rdata[31:0]), .fsm_state(b_state));

    lsu_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_c (
        .clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(c_req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata), .resp_fault(c_resp_fault),
        .mem_valid(c_mem_valid), .mem_ready(mr[2]), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
        .mem_wdata(c_mem_wdata), .mem_wstrb(c_mem_wstrb), .mem_rvalid(mrv[2]),
        .mem_rdata(bus_rdata), .fsm_state(c_state));

    // Selected-instance view
    int          sel;
    logic        o_req_ready, o_resp_valid, o_resp_fault, o_mem_valid, o_mem_we;
    logic [63:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_wstrb;
    logic [2:0]  o_state;

    always_comb begin
        case (sel)
            0: begin
                o_req_ready = a_req_ready; o_resp_valid = a_resp_valid; o_resp_fault = a_resp_fault;
                o_mem_valid = a_mem_valid; o_mem_we = a_mem_we; o_resp_rdata = {32'd0, a_resp_rdata};
                o_mem_addr = {32'd0, a_mem_addr}; o_mem_wdata = {32'd0, a_mem_wdata};
                o_mem_wstrb = {4'd0, a_mem_wstrb}; o_state = a_state;
            end
            1: begin
                o_req_ready = b_req_ready; o_resp_valid = b_resp_valid; o_resp_fault = b_resp_fault;
                o_mem_valid = b_mem_valid; o_mem_we = b_mem_we; o_resp_rdata = {32'd0, b_resp_rdata};
                o_mem_addr = {32'd0, b_mem_addr}; o_mem_wdata = {32'd0, b_mem_wdata};
                o_mem_wstrb = {4'd0, b_mem_wstrb}; o_state = b_state;
            end
            default: begin
                o_req_ready = c_req_ready; o_resp_valid = c_resp_valid; o_resp_fault = c_resp_fault;
                o_mem_valid = c_mem_valid; o_mem_we = c_mem_we; o_resp_rdata = c_resp_rdata;
                o_mem_addr = c_mem_addr; o_mem_wdata = c_mem_wdata;
                o_mem_wstrb = c_mem_wstrb; o_state = c_state;
            end
        endcase
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-side memory (written by DUT beats) and reference memory (written by the model)
    logic [7:0] bus_mem [logic [63:0]];
    logic [7:0] ref_mem [logic [63:0]];

    function automatic logic [7:0] fill(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] bus_rd(input logic [63:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : fill(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction
    function automatic logic [63:0] bus_word(input logic [63:0] wa, input int nb);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < nb; i++) w[8*i +: 8] = bus_rd(wa + 64'(i));
        return w;
    endfunction

    task automatic preload(input logic [63:0] a, input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            bus_mem[a + 64'(i)] = v[8*i +: 8];
            ref_mem[a + 64'(i)] = v[8*i +: 8];
        end
    endtask

    // Reference: little-endian read of the addressed bytes, then extend and clip to XLEN.
    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [2:0] f3, input int xlen);
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 64'(i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, 64'({o_req_ready, o_resp_valid, o_resp_fault, o_mem_valid, o_mem_we}), 64'h10);
        check({tag, "_addr"}, o_mem_addr, 64'd0);
        check({tag, "_wdata"}, o_mem_wdata, 64'd0);
        check({tag, "_wstrb"}, 64'(o_mem_wstrb), 64'd0);
        check({tag, "_rdata"}, o_resp_rdata, 64'd0);
    endtask

    logic [63:0] beat_addr [2];
    logic [7:0]  beat_strb [2];
    logic [63:0] beat_wdata [2];
    int          res_lat, res_beats;
    logic        res_valid, res_fault;
    logic [63:0] res_rdata;

    task automatic access(input logic we, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int st0, input int st1, input bit abort1);
        int cyc, b, stall_left, nb;
        bit have_snap, pending, done;
        logic [63:0] pend_data;
        logic [136:0] snap, cur;
        nb = (sel == 2) ? 8 : 4;
        check("req_ready_idle", 64'(o_req_ready), 64'd1);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rv = 3'b001 << sel;
        tick();
        rv = '0;
        cyc = 1; b = 0; stall_left = 0; have_snap = 0; pending = 0; done = 0;
        res_valid = 0; res_fault = 0; res_rdata = '0; res_lat = 0;
        pend_data = '0; snap = '0;
        while (!done && cyc < 60) begin
            mr = '0; mrv = '0;
            cur = {o_mem_we, o_mem_wstrb, o_mem_addr, o_mem_wdata};
            if (o_resp_valid) begin
                res_valid = 1; res_lat = cyc; res_rdata = o_resp_rdata; res_fault = o_resp_fault;
                done = 1;
            end else if (pending) begin
                if (abort1 && b == 2) begin
                    reset = 1'b1;
                    tick();
                    check_idle("reset_in_wait1");
                    reset = 1'b0;
                    done = 1;
                end else begin
                    mrv = 3'b001 << sel;
                    bus_rdata = pend_data;
                    pending = 0;
                end
            end else if (o_mem_valid && b < 2) begin
                if (!have_snap) begin
                    snap = cur; have_snap = 1;
                    stall_left = (b == 0) ? st0 : st1;
                    check("beat_addr", o_mem_addr, (a & ~64'(nb - 1)) + 64'(b * nb));
                    check("beat_we", 64'(o_mem_we), 64'(we));
                    if (!we) check("read_strb_zero", 64'(o_mem_wstrb), 64'd0);
                end else begin
                    check("beat_stable_hi", 64'(cur[136:64]), 64'(snap[136:64]));
                    check("beat_stable_lo", cur[63:0], snap[63:0]);
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mr = 3'b001 << sel;
                    beat_addr[b] = o_mem_addr; beat_strb[b] = o_mem_wstrb; beat_wdata[b] = o_mem_wdata;
                    if (o_mem_we)
                        for (int i = 0; i < nb; i++)
                            if (o_mem_wstrb[i]) bus_mem[o_mem_addr + 64'(i)] = o_mem_wdata[8*i +: 8];
                    pend_data = bus_word(o_mem_addr, nb);
                    pending = 1; have_snap = 0; b++;
                end
            end else if (o_mem_valid) begin
                check("extra_beat", 64'(b), 64'd2);
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        mr = '0; mrv = '0;
        res_beats = b;
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL timeout cyc=%0d state=%0d", cyc, o_state);
        end
        if (res_valid) begin
            tick();
            check("resp_one_cycle", 64'({o_resp_valid, o_req_ready}), 64'b01);
        end
    endtask

    task automatic run_check(input string tag, input logic we, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] wd, input int st0, input int st1);
        int xlen, nb, n, exp_lat, exp_beats;
        bit allow, rsv, mis, split, fault;
        logic [63:0] exp_ld, g, e;
        xlen = (sel == 2) ? 64 : 32;
        nb = xlen / 8;
        allow = (sel != 1);
        n = 1 << f3[1:0];
        rsv = (f3 == 3'b111) || (we && f3[2]) || (xlen == 32 && f3[1:0] == 2'b11);
        mis = (int'(a % 64'(n)) != 0);
        split = (int'(a % 64'(nb)) + n) > nb;
        fault = rsv || (mis && !allow);
        exp_ld = (we || fault) ? 64'd0 : ref_load(a, f3, xlen);
        exp_beats = fault ? 0 : (split ? 2 : 1);
        exp_lat = fault ? 1 : (split ? 5 + st0 + st1 : 3 + st0);
        access(we, f3, a, wd, st0, st1, 1'b0);
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_fault"}, 64'(res_fault), 64'(fault));
        check({tag, "_rdata"}, res_rdata, exp_ld);
        check({tag, "_beats"}, 64'(res_beats), 64'(exp_beats));
        check({tag, "_latency"}, 64'(res_lat), 64'(exp_lat));
        if (we) begin
            if (!fault)
                for (int i = 0; i < n; i++) ref_mem[a + 64'(i)] = wd[8*i +: 8];
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 8; i++) begin
                    g[8*i +: 8] = bus_rd(a - 64'd8 + 64'(8*k + i));
                    e[8*i +: 8] = ref_rd(a - 64'd8 + 64'(8*k + i));
                end
                check({tag, "_mem"}, g, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1; rv = '0; mr = '0; mrv = '0; sel = 0;
        req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; bus_rdata = '0;
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            tick();
            check_idle("reset");
        end
        reset = 1'b0;
        sel = 0;
        tick();

        // LB sign extension from lane 3
        preload(64'h100, 64'h80FF_7F01, 4);
        run_check("lb", 1'b0, 3'b000, 64'h103, 64'd0, 0, 0);
        check("lb_value", res_rdata, 64'hFFFF_FF80);
        check("lb_addr", beat_addr[0], 64'h100);

        // SH into the upper half-word
        run_check("sh", 1'b1, 3'b001, 64'h102, 64'h0000_BEEF, 0, 0);
        check("sh_strb", 64'(beat_strb[0]), 64'h0C);
        check("sh_wdata", beat_wdata[0], 64'hBEEF_0000);

        // Misaligned LW split over two words
        preload(64'h104, 64'h4433_2211, 4);
        preload(64'h108, 64'h8877_6655, 4);
        run_check("lw_split", 1'b0, 3'b010, 64'h106, 64'd0, 0, 0);
        check("lw_split_value", res_rdata, 64'h6655_4433);
        check("lw_split_lat", 64'(res_lat), 64'd5);

        // Same access without misaligned support
        sel = 1;
        tick();
        run_check("lw_nomis", 1'b0, 3'b010, 64'h106, 64'd0, 0, 0);
        check("lw_nomis_fault", 64'(res_fault), 64'd1);
        check("lw_nomis_lat", 64'(res_lat), 64'd1);

        // Stall in REQ1, then reset during WAIT1, then stale rvalid in IDLE
        sel = 0;
        tick();
        access(1'b0, 3'b010, 64'h10A, 64'd0, 0, 4, 1'b1);
        check("abort_beats", 64'(res_beats), 64'd2);
        mrv = 3'b001; bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        mrv = '0;
        check_idle("stale_rvalid");
        tick();
        check_idle("stale_rvalid_next");
        run_check("after_abort", 1'b0, 3'b010, 64'h104, 64'd0, 0, 0);

        // 64-bit datapath: LWU from the upper word, reserved funct3
        sel = 2;
        tick();
        preload(64'h0, 64'hF000_0000_0000_0000, 8);
        run_check("lwu64", 1'b0, 3'b110, 64'h4, 64'd0, 0, 0);
        check("lwu64_value", res_rdata, 64'h0000_0000_F000_0000);
        run_check("rsv64", 1'b0, 3'b111, 64'h8, 64'd0, 0, 0);
        check("rsv64_fault", 64'(res_fault), 64'd1);

        // Randomized accesses on every configuration
        for (int s = 0; s < 3; s++) begin
            sel = s;
            tick();
            for (int k = 0; k < 50; k++) begin
                run_check("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          64'h1000 + 64'($urandom_range(0, 63)), {$urandom, $urandom},
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
